// File: rtl/ucc_violation_handler.sv
// Response end of the UCC protection monitors: latches the violation cause, drives a timed
// reset pulse into the core and waits for execution to restart at the reset handler.
module ucc_violation_handler #(
    parameter logic [15:0] RESET_HANDLER   = 16'h0000,
    parameter int unsigned RESET_CYCLES    = 4,
    parameter int unsigned RESTART_TIMEOUT = 64,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             system_reset_n,
    input  logic             viol_stack,
    input  logic             viol_region,
    input  logic [15:0]      pc,
    input  logic             cause_clr,
    output logic             cpu_reset,
    output logic [1:0]       viol_cause,
    output logic [CNT_W-1:0] viol_count,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StAssert, StWaitPc} state_e;

    localparam logic [3:0] HoldLoad    = 4'(RESET_CYCLES - 1);
    localparam logic [7:0] RestartLast = 8'(RESTART_TIMEOUT - 1);

    state_e           state;
    logic [3:0]       hold_timer;
    logic [7:0]       restart_timer;
    logic             violation;
    logic [1:0]       cause_set;
    logic [CNT_W-1:0] count_inc;

    assign violation = viol_stack | viol_region;
    assign cause_set = viol_cause | {viol_region, viol_stack};
    // Saturate at all-ones rather than wrap, so attestation never under-reports.
    assign count_inc = (&viol_count) ? viol_count : viol_count + CNT_W'(1);

    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state         <= StIdle;
            cpu_reset     <= 1'b0;
            viol_cause    <= 2'b00;
            viol_count    <= '0;
            busy          <= 1'b0;
            hold_timer    <= 4'd0;
            restart_timer <= 8'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (violation) begin
                        state      <= StAssert;
                        busy       <= 1'b1;
                        cpu_reset  <= 1'b1;
                        viol_cause <= cause_set;
                        viol_count <= count_inc;
                        hold_timer <= HoldLoad;
                    end else if (cause_clr) begin
                        viol_cause <= 2'b00;
                    end
                end

                // Violations here are ignored: the core is already held in reset.
                StAssert: begin
                    if (hold_timer == 4'd0) begin
                        state         <= StWaitPc;
                        cpu_reset     <= 1'b0;
                        restart_timer <= 8'd0;
                    end else begin
                        hold_timer <= hold_timer - 4'd1;
                    end
                end

                StWaitPc: begin
                    if (violation) begin
                        state      <= StAssert;
                        cpu_reset  <= 1'b1;
                        viol_cause <= cause_set;
                        viol_count <= count_inc;
                        hold_timer <= HoldLoad;
                    end else if (pc == RESET_HANDLER) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (restart_timer == RestartLast) begin
                        // Core never reached the handler: reset it again without blaming a monitor.
                        state      <= StAssert;
                        cpu_reset  <= 1'b1;
                        hold_timer <= HoldLoad;
                    end else begin
                        restart_timer <= restart_timer + 8'd1;
                    end
                end

                default: begin
                    state     <= StIdle;
                    busy      <= 1'b0;
                    cpu_reset <= 1'b0;
                end
            endcase
        end
    end

    a_reset_implies_busy: assert property (@(posedge clk) disable iff (!system_reset_n)
        cpu_reset |-> busy);

endmodule
